// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue.
//   IFQ_DEPTH / IFQ_EXCP_W : default queue depth and IF exception width
//   EXCP_ADEF              : fetch address error exception code
//   THERM_*                : thermometer encodings used on if_valid / id_pop
//   therm_count()          : number of slots a thermometer code names
package inst_fetch_queue_pkg;

   localparam int IFQ_DEPTH  = 8;
   localparam int IFQ_EXCP_W = 7;

   localparam logic [IFQ_EXCP_W-1:0] EXCP_ADEF = 7'h08;

   localparam logic [1:0] THERM_NONE = 2'b00;
   localparam logic [1:0] THERM_ONE  = 2'b01;
   localparam logic [1:0] THERM_TWO  = 2'b11;

   // Non-thermometer codes (2'b10) collapse to zero slots.
   function automatic logic [1:0] therm_count(input logic [1:0] t);
      logic [1:0] n;
      case (t)
         THERM_ONE: n = 2'd1;
         THERM_TWO: n = 2'd2;
         default:   n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side buses of the instruction fetch queue.
//   if_* : up to two instructions offered by IF, if_ready back-pressure
//   id_* : two oldest entries presented to ID, id_pop consumption
// master = IF/ID pipeline side, slave = the queue.
interface inst_fetch_queue_if #(
   parameter int EXCP_W = 7
);
   logic [1:0]        if_valid;
   logic [31:0]       if_pc0;
   logic [31:0]       if_pc1;
   logic [31:0]       if_inst0;
   logic [31:0]       if_inst1;
   logic [EXCP_W-1:0] if_excp0;
   logic [EXCP_W-1:0] if_excp1;
   logic              if_ready;

   logic [1:0]        id_valid;
   logic [31:0]       id_pc0;
   logic [31:0]       id_pc1;
   logic [31:0]       id_inst0;
   logic [31:0]       id_inst1;
   logic [EXCP_W-1:0] id_excp0;
   logic [EXCP_W-1:0] id_excp1;
   logic [1:0]        id_pop;

   modport master (
      output if_valid, if_pc0, if_pc1, if_inst0, if_inst1, if_excp0, if_excp1, id_pop,
      input  if_ready, id_valid, id_pc0, id_pc1, id_inst0, id_inst1, id_excp0, id_excp1
   );

   modport slave (
      input  if_valid, if_pc0, if_pc1, if_inst0, if_inst1, if_excp0, if_excp1, id_pop,
      output if_ready, id_valid, id_pc0, id_pc1, id_inst0, id_inst1, id_excp0, id_excp1
   );
endinterface

// File: rtl/inst_fetch_queue_ifq_ram.sv
// Entry storage for the fetch queue: DEPTH x W register array.
//   clk              : clock
//   we0/waddr0/wdata0: write port 0 (older instruction)
//   we1/waddr1/wdata1: write port 1 (younger instruction, never same address as port 0)
//   raddr0/rdata0    : asynchronous read port 0
//   raddr1/rdata1    : asynchronous read port 1
// Contents are never reset; validity is tracked by the queue count.
module ifq_ram #(
   parameter int DEPTH = 8,
   parameter int W     = 71,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we0,
   input  logic [AW-1:0] waddr0,
   input  logic [W-1:0]  wdata0,
   input  logic          we1,
   input  logic [AW-1:0] waddr1,
   input  logic [W-1:0]  wdata1,
   input  logic [AW-1:0] raddr0,
   output logic [W-1:0]  rdata0,
   input  logic [AW-1:0] raddr1,
   output logic [W-1:0]  rdata1
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we0) mem_d[waddr0] = wdata0;
      if (we1) mem_d[waddr1] = wdata1;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata0 = mem_q[raddr0];
   assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue decoupling IF from the two ID decoders.
//   clk   : clock
//   rstn  : synchronous active-low reset (empties the queue)
//   flush : discard every entry and any same-cycle push/pop
//   bus   : fetch push side (if_*) and decode head side (id_*)
// Count is held separately from the pointers so full and empty are distinct.
// if_ready only looks at the registered count, so a same-cycle pop never
// opens room for a push.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH  = IFQ_DEPTH,
   parameter int EXCP_W = IFQ_EXCP_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   inst_fetch_queue_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 64 + EXCP_W;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          push_en;
   logic          push_two;
   logic [1:0]    push_n;
   logic [1:0]    pop_req;
   logic [1:0]    pop_n;
   logic [PW-1:0] head_p1;
   logic [PW-1:0] tail_p1;
   logic [EW-1:0] wdata0, wdata1;
   logic [EW-1:0] rdata0, rdata1;
   logic          ready;

   assign head_p1 = head_q + PW'(1);
   assign tail_p1 = tail_q + PW'(1);

   // Two free slots are required even for a single-instruction push.
   assign ready        = rstn & (count_q <= CW'(DEPTH - 2));
   assign bus.if_ready = ready;

   always_comb begin
      push_en  = bus.if_valid[0] & ready & ~flush;
      push_two = push_en & bus.if_valid[1];
      push_n   = {push_two, push_en & ~push_two};
      pop_req  = therm_count(bus.id_pop);
      // Over-popping is clamped to what is actually held (count is 0 or 1 here).
      pop_n    = (CW'(pop_req) > count_q) ? count_q[1:0] : pop_req;

      head_d   = head_q + PW'(pop_n);
      tail_d   = tail_q + PW'(push_n);
      count_d  = count_q + CW'(push_n) - CW'(pop_n);

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign wdata0 = {bus.if_excp0, bus.if_inst0, bus.if_pc0};
   assign wdata1 = {bus.if_excp1, bus.if_inst1, bus.if_pc1};

   ifq_ram #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_ram (
      .clk    (clk),
      .we0    (push_en),
      .waddr0 (tail_q),
      .wdata0 (wdata0),
      .we1    (push_two),
      .waddr1 (tail_p1),
      .wdata1 (wdata1),
      .raddr0 (head_q),
      .rdata0 (rdata0),
      .raddr1 (head_p1),
      .rdata1 (rdata1)
   );

   // Invalid slots present all-zero data so the decoder sees inst = 0.
   logic valid0, valid1;
   assign valid0       = (count_q != '0);
   assign valid1       = (count_q >= CW'(2));
   assign bus.id_valid = {valid1, valid0};

   assign bus.id_pc0   = valid0 ? rdata0[31:0]    : '0;
   assign bus.id_inst0 = valid0 ? rdata0[63:32]   : '0;
   assign bus.id_excp0 = valid0 ? rdata0[EW-1:64] : '0;
   assign bus.id_pc1   = valid1 ? rdata1[31:0]    : '0;
   assign bus.id_inst1 = valid1 ? rdata1[63:32]   : '0;
   assign bus.id_excp1 = valid1 ? rdata1[EW-1:64] : '0;

endmodule
